// File: rtl/writeback_stage.sv
// writeback_stage: LC-3b MEM/WB register, writeback select, condition-code register and retire counter
package lc3b_pkg;
    typedef struct packed {
        logic       load_regfile;
        logic       load_cc;
        logic [1:0] wbmux_sel;
        logic       drmux_sel;
    } lc3b_control;
endpackage

module writeback_stage
    import lc3b_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_stall,
    input  logic                 in_valid,
    input  logic [15:0]          in_alu,
    input  logic [15:0]          in_mdr,
    input  logic [15:0]          in_ir,
    input  logic [15:0]          in_pc,
    input  lc3b_control          in_ctrl,
    output logic                 rf_we,
    output logic [2:0]           rf_dest,
    output logic [15:0]          rf_data,
    output logic [2:0]           cc,
    output logic                 wb_valid,
    output logic [CNT_WIDTH-1:0] retired
);
    logic                 valid_q, valid_d;
    logic [15:0]          alu_q, alu_d, mdr_q, mdr_d, ir_q, ir_d, pc_q, pc_d;
    lc3b_control          ctrl_q, ctrl_d;
    logic [2:0]           cc_q, cc_d, nzp;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic                 unused_ir;

    always_comb begin
        // a stalled memory stage keeps its instruction, so WB takes a bubble
        valid_d   = mem_stall ? 1'b0 : in_valid;
        alu_d     = mem_stall ? alu_q : in_alu;
        mdr_d     = mem_stall ? mdr_q : in_mdr;
        ir_d      = mem_stall ? ir_q : in_ir;
        pc_d      = mem_stall ? pc_q : in_pc;
        ctrl_d    = mem_stall ? ctrl_q : in_ctrl;
        rf_data   = (ctrl_q.wbmux_sel == 2'b01) ? mdr_q :
                    (ctrl_q.wbmux_sel == 2'b10) ? pc_q : alu_q;
        rf_dest   = ctrl_q.drmux_sel ? 3'b111 : ir_q[11:9];
        rf_we     = valid_q & ctrl_q.load_regfile;
        nzp       = {rf_data[15], rf_data == 16'h0000, !rf_data[15] && rf_data != 16'h0000};
        cc_d      = (valid_q && ctrl_q.load_cc) ? nzp : cc_q;
        retired_d = retired_q + CNT_WIDTH'(valid_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            alu_q     <= '0;
            mdr_q     <= '0;
            ir_q      <= '0;
            pc_q      <= '0;
            ctrl_q    <= '0;
            cc_q      <= 3'b010;
            retired_q <= '0;
        end else begin
            valid_q   <= valid_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            ctrl_q    <= ctrl_d;
            cc_q      <= cc_d;
            retired_q <= retired_d;
        end
    end

    assign unused_ir = ^{ir_q[15:12], ir_q[8:0]};
    assign cc        = cc_q;
    assign wb_valid  = valid_q;
    assign retired   = retired_q;
endmodule
